// File: rtl/mac_array_ws.sv
// mac_array_ws: weight-stationary systolic MAC array of ROW x COL PEs.
// Host drives aligned vectors; rows and psum seeds are skewed internally,
// so each vector emerges on column c of out_s ROW+c cycles after it is sampled.
// Optional build macro MAC_ARRAY_SAT_EN: saturating accumulate plus a sticky
// sat_flag output. Without it, accumulation wraps and sat_flag is absent.
module mac_array_ws #(
   parameter int BW      = 4,
   parameter int PSUM_BW = 16,
   parameter int ROW     = 8,
   parameter int COL     = 8,
   parameter int CNT_BW  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ROW*BW-1:0]      in_w,
   input  logic [1:0]             inst_w,
   input  logic [PSUM_BW*COL-1:0] in_n,
   input  logic                   signed_mode,
   output logic [PSUM_BW*COL-1:0] out_s,
   output logic [COL-1:0]         valid,
   output logic                   done,
   output logic [CNT_BW-1:0]      out_cnt
`ifdef MAC_ARRAY_SAT_EN
   ,
   output logic                   sat_flag
`endif
);

   localparam logic [1:0] INST_LOAD = 2'b01;
   localparam logic [1:0] INST_EXEC = 2'b10;
   // Per-row skew bundle: {signed_mode, inst, activation/weight}
   localparam int HW = BW + 3;

`ifdef MAC_ARRAY_SAT_EN
   // Wide enough that psum + product never overflows before clamping
   localparam int SW = PSUM_BW + 2*BW + 2;
   localparam logic signed [SW-1:0] SMAX = {{(SW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
   localparam logic signed [SW-1:0] SMIN = {{(SW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};
   localparam logic signed [SW-1:0] UMAX = {{(SW-PSUM_BW){1'b0}}, {PSUM_BW{1'b1}}};
   logic [ROW*COL-1:0] sat_vec;
   logic               sat_flag_q;
`else
   // Modulo arithmetic only needs the psum width
   localparam int SW = PSUM_BW;
`endif

   logic [1:0]         inst_clean;
   logic [HW-1:0]      west_bundle [ROW];
   logic [PSUM_BW-1:0] north_psum  [COL];
   logic [BW-1:0]      a_east      [ROW][COL];
   logic [1:0]         inst_east   [ROW][COL];
   logic               sm_east     [ROW][COL];
   logic [PSUM_BW-1:0] psum_south  [ROW][COL];

   logic [PSUM_BW*COL-1:0] out_s_q;
   logic [COL-1:0]         valid_q, valid_d;
   logic                   done_q, done_d;
   logic [CNT_BW-1:0]      out_cnt_q, out_cnt_d;

   // 2'b11 is not a legal command; it behaves as idle
   assign inst_clean = (inst_w == 2'b11) ? 2'b00 : inst_w;

   genvar r, c;

   for (r = 0; r < ROW; r++) begin : g_row_skew
      logic [HW-1:0] row_in;
      assign row_in = {signed_mode, inst_clean, in_w[BW*r +: BW]};
      if (r == 0) begin : g_direct
         assign west_bundle[r] = row_in;
      end else begin : g_delay
         logic [HW-1:0] sr_q [r];
         // Delay row r by r cycles so it meets the psum wavefront
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < r; i++) sr_q[i] <= '0;
            end else begin
               sr_q[0] <= row_in;
               for (int i = 1; i < r; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign west_bundle[r] = sr_q[r-1];
      end
   end

   for (c = 0; c < COL; c++) begin : g_col_skew
      if (c == 0) begin : g_direct
         assign north_psum[c] = in_n[PSUM_BW*c +: PSUM_BW];
      end else begin : g_delay
         logic [PSUM_BW-1:0] sr_q [c];
         // Delay column c seed by c cycles so it meets the activation wavefront
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < c; i++) sr_q[i] <= '0;
            end else begin
               sr_q[0] <= in_n[PSUM_BW*c +: PSUM_BW];
               for (int i = 1; i < c; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign north_psum[c] = sr_q[c-1];
      end
   end

   for (r = 0; r < ROW; r++) begin : g_pe_row
      for (c = 0; c < COL; c++) begin : g_pe_col
         logic [BW-1:0]        a_in, a_q, w_q;
         logic [1:0]           inst_in, inst_q;
         logic                 sm_in, sm_q;
         logic [PSUM_BW-1:0]   psum_in, psum_q, psum_d;
         logic signed [SW-1:0] a_x, w_x, s_x, p_x, sum_x;
         logic                 sat_hit;

         if (c == 0) begin : g_west_edge
            assign a_in    = west_bundle[r][BW-1:0];
            assign inst_in = west_bundle[r][BW+1:BW];
            assign sm_in   = west_bundle[r][BW+2];
         end else begin : g_west_pe
            assign a_in    = a_east[r][c-1];
            assign inst_in = inst_east[r][c-1];
            assign sm_in   = sm_east[r][c-1];
         end

         if (r == 0) begin : g_north_edge
            assign psum_in = north_psum[c];
         end else begin : g_north_pe
            assign psum_in = psum_south[r-1][c];
         end

         // Multiply-accumulate with operand extension chosen by the travelling mode bit
         always_comb begin
            a_x     = '0;
            w_x     = '0;
            s_x     = '0;
            sat_hit = 1'b0;
            if (sm_in) begin
               a_x = SW'(signed'(a_in));
               w_x = SW'(signed'(w_q));
               s_x = SW'(signed'(psum_in));
            end else begin
               a_x = SW'(a_in);
               w_x = SW'(w_q);
               s_x = SW'(psum_in);
            end
            p_x    = a_x * w_x;
            sum_x  = s_x + p_x;
            psum_d = sum_x[PSUM_BW-1:0];
`ifdef MAC_ARRAY_SAT_EN
            if (sm_in) begin
               if (sum_x > SMAX) begin
                  psum_d  = SMAX[PSUM_BW-1:0];
                  sat_hit = 1'b1;
               end else if (sum_x < SMIN) begin
                  psum_d  = SMIN[PSUM_BW-1:0];
                  sat_hit = 1'b1;
               end
            end else if (sum_x > UMAX) begin
               psum_d  = UMAX[PSUM_BW-1:0];
               sat_hit = 1'b1;
            end
`endif
         end

         // PE state: load shifts the old weight east, execute accumulates, idle zeroes psum
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               a_q    <= '0;
               w_q    <= '0;
               inst_q <= 2'b00;
               sm_q   <= 1'b0;
               psum_q <= '0;
            end else begin
               inst_q <= inst_in;
               sm_q   <= sm_in;
               if (inst_in == INST_LOAD) begin
                  w_q <= a_in;
                  a_q <= w_q;
               end else begin
                  a_q <= a_in;
               end
               psum_q <= (inst_in == INST_EXEC) ? psum_d : '0;
            end
         end

         assign a_east[r][c]     = a_q;
         assign inst_east[r][c]  = inst_q;
         assign sm_east[r][c]    = sm_q;
         assign psum_south[r][c] = psum_q;
`ifdef MAC_ARRAY_SAT_EN
         assign sat_vec[r*COL+c] = sat_hit & (inst_in == INST_EXEC);
`endif
      end
   end

   // Bottom-row execute flags become the next valid vector
   always_comb begin
      valid_d = '0;
      for (int i = 0; i < COL; i++) valid_d[i] = (inst_east[ROW-1][i] == INST_EXEC);
      done_d    = valid_q[COL-1] & ~valid_d[COL-1];
      out_cnt_d = out_cnt_q + CNT_BW'(valid_d[COL-1]);
   end

   // Output stage: bottom psums, valid, stream-done pulse and output counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_s_q   <= '0;
         valid_q   <= '0;
         done_q    <= 1'b0;
         out_cnt_q <= '0;
      end else begin
         for (int i = 0; i < COL; i++) out_s_q[PSUM_BW*i +: PSUM_BW] <= psum_south[ROW-1][i];
         valid_q   <= valid_d;
         done_q    <= done_d;
         out_cnt_q <= out_cnt_d;
      end
   end

`ifdef MAC_ARRAY_SAT_EN
   // Sticky record of any clamped accumulate; only reset clears it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sat_flag_q <= 1'b0;
      else        sat_flag_q <= sat_flag_q | (|sat_vec);
   end
   assign sat_flag = sat_flag_q;
`endif

   assign out_s   = out_s_q;
   assign valid   = valid_q;
   assign done    = done_q;
   assign out_cnt = out_cnt_q;

endmodule

// File: tb/tb_mac_array_ws.sv
// Scoreboard bench for mac_array_ws: a 16-bit 8x8 instance for the main
// checks and an 8-bit-psum 8x8 instance for the overflow case.
module tb_mac_array_ws;

   localparam logic [1:0] LD = 2'b01;
   localparam logic [1:0] EX = 2'b10;
   localparam logic [1:0] ID = 2'b00;

   typedef struct {
      logic [15:0] val;
      int          due;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [31:0]  in_w = '0;
   logic [1:0]   inst_w = ID;
   logic [127:0] in_n = '0;
   logic         signed_mode = 1'b0;
   logic [127:0] out_s;
   logic [7:0]   valid;
   logic         done;
   logic [15:0]  out_cnt;

   logic [1:0]   inst8 = ID;
   logic [63:0]  in_n8 = '0;
   logic [63:0]  out_s8;
   logic [7:0]   valid8;
   logic         done8;
   logic [15:0]  out_cnt8;
`ifdef MAC_ARRAY_SAT_EN
   logic         sat_flag;
   logic         sat_flag8;
`endif

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done8_cnt = 0;
   exp_t sbq  [8][$];
   exp_t sbq8 [8][$];
   exp_t e;

   mac_array_ws #(.BW(4), .PSUM_BW(16), .ROW(8), .COL(8), .CNT_BW(16)) u_dut (
      .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
      .signed_mode(signed_mode), .out_s(out_s), .valid(valid), .done(done),
      .out_cnt(out_cnt)
`ifdef MAC_ARRAY_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   mac_array_ws #(.BW(4), .PSUM_BW(8), .ROW(8), .COL(8), .CNT_BW(16)) u_dut8 (
      .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst8), .in_n(in_n8),
      .signed_mode(signed_mode), .out_s(out_s8), .valid(valid8), .done(done8),
      .out_cnt(out_cnt8)
`ifdef MAC_ARRAY_SAT_EN
      , .sat_flag(sat_flag8)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pop and compare whenever a column presents valid data
   always @(negedge clk) begin
      if (reset) begin
         for (int c = 0; c < 8; c++) begin
            if (valid[c]) begin
               total++;
               if (sbq[c].size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_valid col=%0d cyc=%0d got=%0h want=none", c, cyc, out_s[c*16 +: 16]);
               end else begin
                  e = sbq[c].pop_front();
                  if (out_s[c*16 +: 16] !== e.val || cyc != e.due) begin
                     bad++;
                     $display("FAIL out_s col=%0d got=%0h@%0d want=%0h@%0d", c, out_s[c*16 +: 16], cyc, e.val, e.due);
                  end
               end
            end
            if (valid8[c]) begin
               total++;
               if (sbq8[c].size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_valid8 col=%0d cyc=%0d got=%0h want=none", c, cyc, out_s8[c*8 +: 8]);
               end else begin
                  e = sbq8[c].pop_front();
                  if (out_s8[c*8 +: 8] !== e.val[7:0] || cyc != e.due) begin
                     bad++;
                     $display("FAIL out_s8 col=%0d got=%0h@%0d want=%0h@%0d", c, out_s8[c*8 +: 8], cyc, e.val[7:0], e.due);
                  end
               end
            end
         end
         if (done)  done_cnt++;
         if (done8) done8_cnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic flush();
      for (int c = 0; c < 8; c++) begin
         sbq[c].delete();
         sbq8[c].delete();
      end
   endtask

   task automatic drive(input logic [1:0] inst, input logic [3:0] act, input logic [15:0] seed, input logic sm);
      @(negedge clk);
      inst_w      = inst;
      inst8       = ID;
      in_w        = {8{act}};
      in_n        = {8{seed}};
      signed_mode = sm;
   endtask

   // Vector being driven now is sampled at edge cyc+1; column c is due ROW+c later
   task automatic expect_all(input logic [15:0] v);
      for (int c = 0; c < 8; c++) sbq[c].push_back('{val: v, due: cyc + 1 + 8 + c});
   endtask

   task automatic load8(input logic [3:0] wv);
      for (int k = 0; k < 8; k++) drive(LD, wv, 16'd0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      inst_w = ID;
      inst8 = ID;
      flush();
      @(negedge clk);
      reset = 1'b1;
      done_cnt = 0;
      done8_cnt = 0;
   endtask

   task automatic wait_drain(input string name);
      int left;
      int n;
      left = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n = 0;
         for (int c = 0; c < 8; c++) n += sbq[c].size() + sbq8[c].size();
         left = n;
         if (n == 0) break;
      end
      chk(name, left, 0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      // Reset asserted with random inputs: everything must read zero
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_w = $urandom;
         inst_w = 2'($urandom_range(0, 3));
         in_n = {$urandom, $urandom, $urandom, $urandom};
         signed_mode = 1'($urandom_range(0, 1));
      end
      #1;
      chk("rst_out_s", out_s[31:0] | out_s[127:96], 0);
      chk("rst_valid", valid, 0);
      chk("rst_done", done, 0);
      chk("rst_out_cnt", out_cnt, 0);
      drive(ID, 4'd0, 16'd0, 1'b0);
      reset = 1'b1;
      repeat (12) drive(ID, 4'd0, 16'd0, 1'b0);
      chk("idle_out_s", out_s[63:0] | out_s[127:64], 0);
      chk("idle_out_cnt", out_cnt, 0);
      chk("idle_done_cnt", done_cnt, 0);

      // Unsigned: weights 1, activations 3, seed 0 -> 24 per column
      do_reset();
      load8(4'd1);
      drive(EX, 4'd3, 16'd0, 1'b0);
      expect_all(16'd24);
      drive(ID, 4'd0, 16'd0, 1'b0);
      wait_drain("drain_unsigned");
      chk("unsigned_done_cnt", done_cnt, 1);
      chk("unsigned_out_cnt", out_cnt, 1);

      // Weights -1: signed gives 5-16=-11, unsigned gives 5+8*30=245
      do_reset();
      load8(4'hF);
      drive(EX, 4'd2, 16'd5, 1'b1);
      expect_all(16'hFFF5);
      drive(EX, 4'd2, 16'd5, 1'b0);
      expect_all(16'd245);
      drive(ID, 4'd0, 16'd0, 1'b0);
      wait_drain("drain_signed");
      chk("signed_done_cnt", done_cnt, 1);
      chk("signed_out_cnt", out_cnt, 2);

      // 8-bit psum: 8*225 = 1800 wraps to 8, or clamps to 255
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         inst_w = ID;
         inst8 = LD;
         in_w = {8{4'hF}};
         signed_mode = 1'b0;
      end
      @(negedge clk);
      inst8 = EX;
      in_w = {8{4'hF}};
      for (int c = 0; c < 8; c++) begin
`ifdef MAC_ARRAY_SAT_EN
         sbq8[c].push_back('{val: 16'd255, due: cyc + 1 + 8 + c});
`else
         sbq8[c].push_back('{val: 16'd8, due: cyc + 1 + 8 + c});
`endif
      end
      drive(ID, 4'd0, 16'd0, 1'b0);
      wait_drain("drain_overflow");
      chk("overflow_out_cnt8", out_cnt8, 1);
      chk("overflow_done8_cnt", done8_cnt, 1);
`ifdef MAC_ARRAY_SAT_EN
      chk("sat_flag8", sat_flag8, 1);
      chk("sat_flag_main", sat_flag, 0);
`endif

      // Streaming: 20 back-to-back vectors, out = 8*(k mod 16) + k
      do_reset();
      load8(4'd1);
      for (int k = 1; k <= 20; k++) begin
         drive(EX, 4'(k), 16'(k), 1'b0);
         expect_all(16'(8 * (k % 16) + k));
      end
      drive(ID, 4'd0, 16'd0, 1'b0);
      wait_drain("drain_stream");
      chk("stream_done_cnt", done_cnt, 1);
      chk("stream_out_cnt", out_cnt, 20);

      // Reset 3 vectors into a 10-vector stream: all cleared, no done
      done_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         drive(EX, 4'd5, 16'd7, 1'b0);
         expect_all(16'd47);
      end
      @(negedge clk);
      reset = 1'b0;
      flush();
      #1;
      chk("mid_rst_out_s", out_s[63:0] | out_s[127:64], 0);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_out_cnt", out_cnt, 0);
      @(negedge clk);
      inst_w = ID;
      reset = 1'b1;
      repeat (20) drive(ID, 4'd0, 16'd0, 1'b0);
      chk("mid_rst_no_done", done_cnt, 0);
      // Weights were cleared, so the result is just the per-column seed
      drive(EX, 4'd3, 16'd0, 1'b0);
      for (int c = 0; c < 8; c++) begin
         in_n[c*16 +: 16] = 16'(100 + c);
         sbq[c].push_back('{val: 16'(100 + c), due: cyc + 1 + 8 + c});
      end
      drive(ID, 4'd0, 16'd0, 1'b0);
      wait_drain("drain_post_reset");
      chk("post_reset_out_cnt", out_cnt, 1);
      chk("post_reset_done_cnt", done_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule

// File: doc/mac_array_ws.md
Name: mac_array_ws

Overview:
- Parametrised weight-stationary systolic MAC array of ROW x COL processing elements (PEs), built internally with no sub-module dependency.
- Successor to the fixed 8x8 array. Adds:
  - internal input/psum skewing, so the host drives aligned vectors;
  - signed/unsigned mode;
  - a stream-done pulse and an output counter.
- Sits between the activation/weight SRAM reader (west) and the psum accumulator/OFIFO (south).

Parameters:
- BW, 4, activation/weight bit width.
- PSUM_BW, 16, partial-sum width.
- ROW, 8, PE rows (≥1).
- COL, 8, PE columns (≥1).
- CNT_BW, 16, width of out_cnt.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_w  input  ROW*BW  row r at bits [BW*(r+1)-1:BW*r]; weight during load, activation during execute.
- inst_w  input  2  bit1 execute, bit0 load; 2'b11 is illegal and treated as 2'b00.
- in_n  input  PSUM_BW*COL  psum seed per column.
- signed_mode  input  1  1 = two's-complement operands; sampled with inst_w and skewed identically.
- out_s  output  PSUM_BW*COL  bottom-row psums.
- valid  output  COL  per-column out_s valid.
- done  output  1  one-cycle pulse when an execute stream has fully drained.
- out_cnt  output  CNT_BW  count of valid[COL-1] assertions since reset; wraps.

Behaviour:
- Reset (reset=0, async): all PE weights, activation/psum/inst registers, skew registers, out_s, valid, done and out_cnt clear to 0.
- Skew:
  - Row r in_w, inst_w and signed_mode pass through r registers (row 0 direct).
  - in_n column c passes through c registers.
- Horizontal pipeline: each PE registers activation, inst and signed_mode and forwards them east.
- Vertical pipeline: each PE registers its psum output and forwards it south.
- Load (PE inst=01):
  - PE latches the incoming value as its weight and passes its old weight east: an east-shift chain.
  - After COL consecutive load vectors k=0..COL-1, PE(r,c) holds the row-r element of vector k=COL-1-c.
  - Psum output is 0; valid is 0.
- Execute (PE inst=10): psum_out <= psum_in + a*w.
  - Unsigned mode: product zero-extended to PSUM_BW.
  - Signed mode: operands and product sign-extended.
  - Sum wraps modulo 2^PSUM_BW unless MAC_ARRAY_SAT_EN is defined.
- Idle (00): PE psum_out <= 0; the weight is held.
- Latency: a vector sampled at edge t appears on out_s[c] after edge t+ROW+c, with valid[c]=1 for that one cycle. Back-to-back vectors give back-to-back outputs, with throughput of 1 vector per cycle.
- valid[c] is the registered execute flag of PE(ROW-1,c).
- done: asserted for one cycle on the cycle after valid[COL-1] falls 1→0.
- out_cnt: increments on each cycle valid[COL-1]=1.
- Load/execute interleave:
  - A load vector followed immediately by execute is legal.
  - Each PE switches in order, because inst travels with the data.
  - Weights are not corrupted by in-flight execute.
- Reset mid-stream: all in-flight data is discarded; no done pulse is generated for the aborted stream.

Optional Feature:
- Macro MAC_ARRAY_SAT_EN.
- Defined: each PE accumulate saturates to the PSUM_BW range.
  - Unsigned range: [0, 2^PSUM_BW-1].
  - Signed range: [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
  - An extra output sat_flag (1 bit) is added; it is a sticky OR of any saturation, cleared only by reset.
- Undefined: modulo wrap, and no sat_flag port.

Test Plan:
- Reset: drive random inputs while reset=0 → out_s=0, valid=0, done=0, out_cnt=0. Release reset → all outputs stay 0 until an execute.
- Load/execute unsigned (ROW=COL=8):
  - Load 8 vectors of all-1 weights, then execute 1 vector with in_w all rows=3 and in_n=0.
  - Required: out_s[c]=24 after edge t+8+c; valid[c] high exactly one cycle each; done pulses once after valid[7] falls; out_cnt=1.
- Signed mode:
  - Weights all -1 (4'hF), activations all 2, signed_mode=1, in_n=5 → each column = 5-16 = -11 (16'hFFF5).
  - Same stimulus with signed_mode=0 → 5+8*30 = 245.
- Streaming: 20 back-to-back execute vectors → valid[c] high 20 consecutive cycles; out_cnt=20; exactly one done pulse.
- Overflow: PSUM_BW=8, weights 15, activations 15, unsigned, in_n=0.
  - Without the macro: 8*225 = 1800 mod 256 = 8.
  - With MAC_ARRAY_SAT_EN: 255 and sat_flag=1.
- Reset mid-execute: assert reset 3 cycles into a 10-vector stream → outputs clear immediately, no done pulse, weights cleared (post-reset execute yields in_n values).
